conv3x3_ctrl: RTL and testbench
===============================

# conv3x3_ctrl

Sequencer for the 3x3 convolution input router. It walks the 3x3 sliding-window origin across an IFMAP_H x IFMAP_W input feature map in raster order. For each window it drives the router's load/shift select: load the filter on the first window, shift the ifmap on every later window. It also produces a pipeline-aligned valid and a done pulse for the downstream PE array. It sits between the layer-level start logic, the ifmap window buffer (addressed by win_row/win_col) and the input router.

## Interface
- IFMAP_H, default 8: ifmap rows; must be >= 3. Output rows OH = IFMAP_H-2.
- IFMAP_W, default 8: ifmap columns; must be >= 3. Output columns OW = IFMAP_W-2.
- ROW_W / COL_W (localparam): $clog2(IFMAP_H) / $clog2(IFMAP_W), minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin one layer pass; sampled only in IDLE.
- pe_ready  in  1  downstream can accept a window this cycle.
- router_state  out  1  router select: 1 = load ifmap+filter, 0 = shift ifmap only.
- win_row  out  ROW_W  top-left row of the window being issued.
- win_col  out  COL_W  top-left column of the window being issued.
- win_valid  out  1  a window is issued this cycle; the router captures it at this edge.
- pe_valid  out  1  win_valid delayed 1 cycle; aligned with the router outputs.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a pass.

## Operation
- States: IDLE, LOAD, SHIFT, DRAIN, DONE.
- issue = (state is LOAD or SHIFT) && pe_ready. win_valid = issue.
- router_state = (state==LOAD) && pe_ready. While stalled, the router is driven to shift, so no repeated filter load and no spurious wb_write_en.
- IDLE: row/col counters are 0. start=1 -> LOAD.
- LOAD: window (0,0). On issue:
  - -> SHIFT, and the counters advance;
  - if OH*OW == 1, -> DRAIN instead.
- SHIFT, on each issue:
  - col+1;
  - if col == OW-1, col wraps to 0 and row+1;
  - if (row,col) == (OH-1,OW-1), -> DRAIN with no advance.
- Stall (pe_ready=0 in LOAD/SHIFT): state, win_row and win_col hold.
- DRAIN: one cycle, pe_valid=1 for the last window. -> DONE.
- DONE: done=1 for one cycle. Counters clear to 0. -> IDLE.
- start outside IDLE is ignored. start in the DONE cycle is also ignored.
- win_row/win_col are combinational from the registered counters. pe_valid and done are registered.

## Timing
- Reset (async, rst_n=0): state=IDLE, counters=0, pe_valid=0. All outputs 0 immediately and held until rst_n releases.
- Reset mid-pass aborts the pass with no done pulse. The next pass requires a new start.
- start sampled at edge t -> first issue (LOAD) in cycle t+1 if pe_ready=1.
- pe_valid for a window is high in the cycle after its win_valid.
- With pe_ready tied 1, for a start sampled at cycle 0:
  - windows are issued in cycles 1 .. OH*OW;
  - DRAIN is cycle OH*OW+1;
  - done=1 in cycle OH*OW+2;
  - busy falls in cycle OH*OW+3.
- Each stall cycle delays all subsequent events by exactly one cycle.
- Exactly OH*OW win_valid pulses and OH*OW pe_valid pulses per pass. Exactly one router_state=1 pulse per pass.

## Configuration
- CONV_CTRL_PERF_CNT_EN defined:
  - adds output port stall_cnt [15:0], the number of cycles in LOAD/SHIFT with pe_ready=0;
  - cleared to 0 on accepted start and on reset;
  - saturates at 16'hFFFF;
  - holds its value after done until the next start.
- Not defined: port and counter are absent. All other behaviour is identical.

## Test plan
- Default 8x8 ifmap, pe_ready=1, start pulse at cycle 0:
  - 36 win_valid in cycles 1..36, origins (0,0),(0,1)..(0,5),(1,0)..(5,5);
  - router_state=1 only in cycle 1;
  - pe_valid in cycles 2..37;
  - done in cycle 38.
- pe_ready=0 in LOAD for 3 cycles, then 1:
  - router_state stays 0 while stalled and win_row/col stay (0,0);
  - router_state=1 in the first ready cycle;
  - done arrives 3 cycles later than in the first test.
- pe_ready=0 for 2 cycles at origin (2,5) (row-wrap point):
  - holds at (2,5); next issue is (3,0);
  - with CONV_CTRL_PERF_CNT_EN, stall_cnt=2 at done.
- IFMAP_H=IFMAP_W=3:
  - a single window issued with router_state=1 in cycle 1;
  - DRAIN in cycle 2, done in cycle 3.
- rst_n low at cycle 10 mid-pass:
  - all outputs 0 asynchronously and no done;
  - a start after release restarts at (0,0) with router_state=1.
- start pulsed again at cycles 5 and 38 during the 8x8 pass: ignored; exactly 36 win_valid and one done.

Source files
------------

// File: rtl/conv3x3_ctrl.sv
// conv3x3_ctrl: sequencer for the 3x3 convolution input router.
// Walks the window origin over the ifmap in raster order, selects filter
// load for the first window and ifmap shift for the rest, and produces a
// pipeline-aligned pe_valid plus a one-cycle done pulse.
// Optional feature macro: CONV_CTRL_PERF_CNT_EN adds the stall_cnt_o port.
module conv3x3_ctrl #(
    parameter int IFMAP_H = 8,
    parameter int IFMAP_W = 8,
    localparam int ROW_W = (IFMAP_H > 1) ? $clog2(IFMAP_H) : 1,
    localparam int COL_W = (IFMAP_W > 1) ? $clog2(IFMAP_W) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             pe_ready_i,
    output logic             router_state_o,
    output logic [ROW_W-1:0] win_row_o,
    output logic [COL_W-1:0] win_col_o,
    output logic             win_valid_o,
    output logic             pe_valid_o,
    output logic             busy_o,
    output logic             done_o
`ifdef CONV_CTRL_PERF_CNT_EN
    ,
    output logic [15:0]      stall_cnt_o
`endif
);

    localparam int OH = IFMAP_H - 2;
    localparam int OW = IFMAP_W - 2;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OH - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(OW - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DRAIN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             pe_valid_q;
    logic             done_q;
    logic             issuing_state;
    logic             issue;
    logic             last_win;

    // A window goes out whenever we are in an issuing state and the PE array can take it.
    always_comb begin
        issuing_state = (state_q == LOAD) || (state_q == SHIFT);
        issue         = issuing_state && pe_ready_i;
        last_win      = (row_q == LAST_ROW) && (col_q == LAST_COL);
    end

    // Next-state and counter advance; stalls simply hold everything.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                row_d = '0;
                col_d = '0;
                if (start_i) begin
                    state_d = LOAD;
                end
            end
            LOAD, SHIFT: begin
                if (issue) begin
                    if (last_win) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = SHIFT;
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                row_d   = '0;
                col_d   = '0;
            end
            default: begin
                state_d = IDLE;
                row_d   = '0;
                col_d   = '0;
            end
        endcase
    end

    // State, window counters and the registered valid/done outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            pe_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            pe_valid_q <= issue;
            done_q     <= (state_d == DONE);
        end
    end

    // Router is told to load only when the first window is really accepted.
    always_comb begin
        router_state_o = (state_q == LOAD) && pe_ready_i;
        win_valid_o    = issue;
        win_row_o      = row_q;
        win_col_o      = col_q;
        pe_valid_o     = pe_valid_q;
        busy_o         = (state_q != IDLE);
        done_o         = done_q;
    end

`ifdef CONV_CTRL_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Stall counter: cleared on an accepted start, saturating count of blocked issue cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && start_i) begin
            stall_cnt_d = '0;
        end else if (issuing_state && !pe_ready_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv3x3_ctrl.sv
// tb_conv3x3_ctrl: scoreboard bench for conv3x3_ctrl.
// The stimulus side decides the pe_ready pattern of each pass, derives the
// expected window order and event cycles from it, and queues them; the
// monitor pops and compares whenever the DUT presents an output.
module tb_conv3x3_ctrl;

    localparam int H  = 8;
    localparam int W  = 8;
    localparam int OH = H - 2;
    localparam int OW = W - 2;
    localparam int N  = OH * OW;

    typedef struct {
        int cyc;
        int row;
        int col;
        int rs;
    } win_t;

    logic       clk = 1'b0;
    logic       rstN;
    logic       startIn;
    logic       peReady;
    logic       routerState;
    logic [2:0] winRow;
    logic [2:0] winCol;
    logic       winValid;
    logic       peValid;
    logic       busy;
    logic       done;

    logic       start3;
    logic       routerState3;
    logic [1:0] winRow3;
    logic [1:0] winCol3;
    logic       winValid3;
    logic       peValid3;
    logic       busy3;
    logic       done3;

`ifdef CONV_CTRL_PERF_CNT_EN
    logic [15:0] stallCnt;
    logic [15:0] stallCnt3;
`endif

    int   cyc = 0;
    int   testsRun = 0;
    int   failCount = 0;
    int   busyFrom = 1;
    int   busyTo = 0;
    int   stallsBefore [0:N-1];
    bit   readySeq [0:255];
    win_t winQ[$];
    int   peQ[$];
    int   doneQ[$];
    int   stallQ[$];

    conv3x3_ctrl #(.IFMAP_H(H), .IFMAP_W(W)) dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .start_i        (startIn),
        .pe_ready_i     (peReady),
        .router_state_o (routerState),
        .win_row_o      (winRow),
        .win_col_o      (winCol),
        .win_valid_o    (winValid),
        .pe_valid_o     (peValid),
        .busy_o         (busy),
        .done_o         (done)
`ifdef CONV_CTRL_PERF_CNT_EN
        ,
        .stall_cnt_o    (stallCnt)
`endif
    );

    conv3x3_ctrl #(.IFMAP_H(3), .IFMAP_W(3)) dut3 (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .start_i        (start3),
        .pe_ready_i     (1'b1),
        .router_state_o (routerState3),
        .win_row_o      (winRow3),
        .win_col_o      (winCol3),
        .win_valid_o    (winValid3),
        .pe_valid_o     (peValid3),
        .busy_o         (busy3),
        .done_o         (done3)
`ifdef CONV_CTRL_PERF_CNT_EN
        ,
        .stall_cnt_o    (stallCnt3)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle number: a cycle starts at a rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Runaway guard so the bench can never hang.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        testsRun++;
        if (act != exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkZeros(input string tag);
        checkOutput({tag, "_win_valid"}, winValid, 0);
        checkOutput({tag, "_pe_valid"}, peValid, 0);
        checkOutput({tag, "_router_state"}, routerState, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_win_row"}, winRow, 0);
        checkOutput({tag, "_win_col"}, winCol, 0);
        checkOutput({tag, "_busy3"}, busy3, 0);
`ifdef CONV_CTRL_PERF_CNT_EN
        checkOutput({tag, "_stall_cnt"}, stallCnt, 0);
`endif
    endtask

    // Monitor: compares DUT outputs against the queued expectations every cycle.
    always @(negedge clk) begin : monitor
        win_t e;
        int   expStall;
        if (rstN) begin
            if (winValid) begin
                if (winQ.size() == 0) begin
                    checkOutput("win_unexpected", 1, 0);
                end else begin
                    e = winQ.pop_front();
                    checkOutput("win_cycle", cyc, e.cyc);
                    checkOutput("win_row", winRow, e.row);
                    checkOutput("win_col", winCol, e.col);
                    checkOutput("router_state", routerState, e.rs);
                end
            end else begin
                checkOutput("router_state_quiet", routerState, 0);
                if (winQ.size() > 0) begin
                    checkOutput("hold_row", winRow, winQ[0].row);
                    checkOutput("hold_col", winCol, winQ[0].col);
                end
            end
            if (peValid) begin
                if (peQ.size() == 0) checkOutput("pe_valid_unexpected", 1, 0);
                else checkOutput("pe_valid_cycle", cyc, peQ.pop_front());
            end
            if (done) begin
                if (doneQ.size() == 0) begin
                    checkOutput("done_unexpected", 1, 0);
                end else begin
                    checkOutput("done_cycle", cyc, doneQ.pop_front());
                    expStall = stallQ.pop_front();
`ifdef CONV_CTRL_PERF_CNT_EN
                    checkOutput("stall_cnt", stallCnt, expStall);
`endif
                end
            end
            checkOutput("busy", busy, (cyc >= busyFrom && cyc <= busyTo) ? 1 : 0);
        end
    end

    // One 8x8 pass: stallsBefore[k] ready-low cycles precede window k.
    task automatic applyStimulus(input int abortRel, input bit extraStarts);
        int   s;
        int   total;
        int   pos;
        int   issueCyc;
        int   lastRel;
        win_t e;
        @(posedge clk); #1;
        s     = cyc;
        total = 0;
        pos   = 1;
        for (int w = 0; w < N; w++) begin
            for (int z = 0; z < stallsBefore[w]; z++) begin
                readySeq[pos] = 1'b0;
                pos++;
            end
            total += stallsBefore[w];
            readySeq[pos] = 1'b1;
            issueCyc = s + pos;
            pos++;
            if (abortRel < 0 || issueCyc < s + abortRel) begin
                e.cyc = issueCyc;
                e.row = w / OW;
                e.col = w % OW;
                e.rs  = (w == 0) ? 1 : 0;
                winQ.push_back(e);
            end
            if (abortRel < 0 || issueCyc + 1 < s + abortRel) peQ.push_back(issueCyc + 1);
        end
        lastRel = N + total + 4;
        for (int r = pos; r <= lastRel; r++) readySeq[r] = 1'($urandom);
        busyFrom = s + 1;
        if (abortRel < 0) begin
            busyTo = s + N + total + 2;
            doneQ.push_back(s + N + total + 2);
            stallQ.push_back(total);
        end else begin
            busyTo = s + abortRel - 1;
        end
        startIn = 1'b1;
        peReady = 1'($urandom);
        for (int r = 1; r <= lastRel; r++) begin
            @(posedge clk); #1;
            startIn = extraStarts && (r == 5 || r == 38);
            peReady = readySeq[r];
            if (r == abortRel) begin
                #1 rstN = 1'b0;
                #1 checkZeros("abort");
                repeat (2) @(posedge clk);
                #3 rstN = 1'b1;
                break;
            end
        end
        startIn = 1'b0;
    endtask

    task automatic clearStalls();
        for (int k = 0; k < N; k++) stallsBefore[k] = 0;
    endtask

    // Single-window 3x3 instance: fixed cycle-by-cycle expectations after start.
    task automatic run3x3();
        @(posedge clk); #1;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        @(negedge clk);
        checkOutput("s3_win_valid_c1", winValid3, 1);
        checkOutput("s3_router_state_c1", routerState3, 1);
        checkOutput("s3_row_c1", winRow3, 0);
        checkOutput("s3_col_c1", winCol3, 0);
        checkOutput("s3_busy_c1", busy3, 1);
        @(negedge clk);
        checkOutput("s3_win_valid_c2", winValid3, 0);
        checkOutput("s3_pe_valid_c2", peValid3, 1);
        checkOutput("s3_done_c2", done3, 0);
        @(negedge clk);
        checkOutput("s3_done_c3", done3, 1);
        checkOutput("s3_pe_valid_c3", peValid3, 0);
        checkOutput("s3_busy_c3", busy3, 1);
        @(negedge clk);
        checkOutput("s3_busy_c4", busy3, 0);
        checkOutput("s3_done_c4", done3, 0);
    endtask

    // Test sequence: directed passes from the test plan, then random stall patterns.
    initial begin
        rstN    = 1'b0;
        startIn = 1'b0;
        peReady = 1'b0;
        start3  = 1'b0;
        clearStalls();
        repeat (2) @(posedge clk);
        #1 checkZeros("reset");
        #2 rstN = 1'b1;
        repeat (2) @(posedge clk);

        applyStimulus(-1, 1'b0);
        stallsBefore[0] = 3;
        applyStimulus(-1, 1'b0);
        clearStalls();
        stallsBefore[2 * OW + 5] = 2;
        applyStimulus(-1, 1'b0);
        clearStalls();
        applyStimulus(-1, 1'b1);
        applyStimulus(10, 1'b0);
        applyStimulus(-1, 1'b0);
        run3x3();

        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < N; k++) begin
                stallsBefore[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            applyStimulus(-1, 1'b0);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                peReady = 1'($urandom);
            end
        end

        repeat (3) @(posedge clk);
        checkOutput("win_queue_left", winQ.size(), 0);
        checkOutput("pe_queue_left", peQ.size(), 0);
        checkOutput("done_queue_left", doneQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
